prbs_checker: RTL

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// PRBS checker for XNOR-feedback Fibonacci LFSR streams: hunts for LOCK_CNT
// consecutive predicted words, then free-runs the expected sequence and counts errors.
module prbs_checker #(
    parameter int NUM_BITS = 8,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                i_Clear,
    input  logic                i_Data_DV,
    input  logic [NUM_BITS-1:0] i_Data,
    output logic                o_Locked,
    output logic                o_Err_Pulse,
    output logic                o_Sync_Lost,
    output logic [ERR_W-1:0]    o_Err_Count,
    output logic                o_Dbg_State
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    // Tap masks from the XAPP052 table; tap k maps to bit k-1.
    function automatic logic [31:0] tap_mask(input int n);
        case (n)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    localparam logic [31:0]         TAP_MASK  = tap_mask(NUM_BITS);
    localparam logic [NUM_BITS-1:0] TAPS      = TAP_MASK[NUM_BITS-1:0];
    localparam logic [3:0]          LOCK_LAST = 4'(LOCK_CNT - 1);
    localparam logic [3:0]          LOSS_LAST = 4'(LOSS_CNT - 1);

    // Every table entry has 2 or 4 taps, so the XNOR chain equals an inverted XOR.
    function automatic logic [NUM_BITS-1:0] next_word(input logic [NUM_BITS-1:0] w);
        return {w[NUM_BITS-2:0], ~^(w & TAPS)};
    endfunction

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic [NUM_BITS-1:0] exp_q, exp_d;
    logic [3:0]          match_q, match_d;
    logic [3:0]          miss_q, miss_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic                err_pulse_q, err_pulse_d;
    logic                sync_lost_q, sync_lost_d;

    logic hunt_hit;
    logic lock_miss;

    // The all-ones lockup word predicts itself, so it is excluded from matching.
    assign hunt_hit  = prev_vld_q && (i_Data == next_word(prev_q)) && (i_Data != '1);
    assign lock_miss = (i_Data != exp_q);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state_q <= HUNT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_Data_DV) begin
            case (state_q)
                HUNT:    if (hunt_hit && match_q == LOCK_LAST) state_d = LOCKED;
                LOCKED:  if (lock_miss && miss_q == LOSS_LAST) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        exp_d       = exp_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        sync_lost_d = 1'b0;
        if (i_Data_DV) begin
            if (state_q == HUNT) begin
                prev_d     = i_Data;
                prev_vld_d = 1'b1;
                match_d    = hunt_hit ? match_q + 4'd1 : 4'd0;
                if (state_d == LOCKED) begin
                    exp_d   = next_word(i_Data);
                    match_d = 4'd0;
                    miss_d  = 4'd0;
                end
            end else begin
                exp_d = next_word(exp_q);
                if (lock_miss) begin
                    err_pulse_d = 1'b1;
                    miss_d      = miss_q + 4'd1;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                    if (state_d == HUNT) begin
                        sync_lost_d = 1'b1;
                        match_d     = 4'd0;
                        miss_d      = 4'd0;
                        prev_vld_d  = 1'b0;
                    end
                end else begin
                    miss_d = 4'd0;
                end
            end
        end
        if (i_Clear) err_cnt_d = '0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            exp_q       <= '0;
            match_q     <= 4'd0;
            miss_q      <= 4'd0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            sync_lost_q <= sync_lost_d;
        end
    end

    always_comb begin
        o_Locked    = (state_q == LOCKED);
        o_Dbg_State = state_q;
        o_Err_Pulse = err_pulse_q;
        o_Sync_Lost = sync_lost_q;
        o_Err_Count = err_cnt_q;
    end

endmodule
